// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and derived sync windows shared by the video timing blocks.
// Coordinates are unsigned and CW bits wide throughout the subsystem.
package vga_timing_pkg;

    localparam int CW = 10;

    localparam int   DEF_CLK_DIV     = 4;
    localparam int   DEF_H_ACTIVE    = 640;
    localparam int   DEF_H_FP        = 16;
    localparam int   DEF_H_SYNC      = 96;
    localparam int   DEF_H_BP        = 48;
    localparam int   DEF_V_ACTIVE    = 480;
    localparam int   DEF_V_FP        = 10;
    localparam int   DEF_V_SYNC      = 2;
    localparam int   DEF_V_BP        = 33;
    localparam logic DEF_SYNC_ACTIVE = 1'b0;
    localparam int   DEF_SYNC_DLY    = 1;

    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

    // Inclusive window test on an unsigned coordinate.
    function automatic logic in_window(input logic [CW-1:0] v, input int lo, input int hi);
        return (v >= CW'(lo)) && (v <= CW'(hi));
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate enable: one-clk pulse every CLK_DIV clocks, first pulse at edge CLK_DIV after reset.
// CLK_DIV = 1 yields a permanently asserted enable.
module pix_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pix_tick_gen: CLK_DIV must be >= 1");
    end

    logic [DW-1:0] r_div_cnt;
    logic          r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= (r_div_cnt == LAST) ? '0 : r_div_cnt + DW'(1);
            r_tick    <= (r_div_cnt == LAST);
        end
    end

    assign pix_tick = r_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, vid_on qualifier and VGA syncs; syncs are delayed SYNC_DLY clks so they line up
// with the downstream registered pixel colour. Decodes use next-state counters so they align with pixel_x/y.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV     = DEF_CLK_DIV,
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE,
    parameter int   SYNC_DLY    = DEF_SYNC_DLY
) (
    input  logic          clk,
    input  logic          rst,
    output logic          pix_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          vid_on,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = HS_LO + H_SYNC - 1;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = VS_LO + V_SYNC - 1;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);

    if ((H_TOT > (1 << CW)) || (V_TOT > (1 << CW))) begin : g_bad_geom
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the coordinate range");
    end

    logic          w_tick;
    logic [CW-1:0] w_x_nxt;
    logic [CW-1:0] w_y_nxt;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_vid;
    logic          r_hs_raw;
    logic          r_vs_raw;
    logic          r_frame;

    pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (w_tick)
    );

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_tick) begin
            if (r_x == H_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == V_LAST) ? '0 : r_y + CW'(1);
            end else begin
                w_x_nxt = r_x + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_vid    <= 1'b0;
            r_hs_raw <= ~SYNC_ACTIVE;
            r_vs_raw <= ~SYNC_ACTIVE;
            r_frame  <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_vid    <= (w_x_nxt < CW'(H_ACTIVE)) && (w_y_nxt < CW'(V_ACTIVE));
            r_hs_raw <= in_window(w_x_nxt, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vs_raw <= in_window(w_y_nxt, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_frame  <= w_tick && (r_x == H_LAST) && (r_y == V_LAST);
        end
    end

    // Delay line resets to the idle level so a reset never leaves a partial sync pulse in flight.
    if (SYNC_DLY == 0) begin : g_nodly
        assign hsync = r_hs_raw;
        assign vsync = r_vs_raw;
    end else begin : g_dly
        logic [SYNC_DLY-1:0] r_hs_sr;
        logic [SYNC_DLY-1:0] r_vs_sr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hs_sr <= {SYNC_DLY{~SYNC_ACTIVE}};
                r_vs_sr <= {SYNC_DLY{~SYNC_ACTIVE}};
            end else begin
                r_hs_sr[0] <= r_hs_raw;
                r_vs_sr[0] <= r_vs_raw;
                for (int i = 1; i < SYNC_DLY; i++) begin
                    r_hs_sr[i] <= r_hs_sr[i-1];
                    r_vs_sr[i] <= r_vs_sr[i-1];
                end
            end
        end

        assign hsync = r_hs_sr[SYNC_DLY-1];
        assign vsync = r_vs_sr[SYNC_DLY-1];
    end

    assign pix_tick    = w_tick;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign vid_on      = r_vid;
    assign frame_start = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default geometry for line timing, a reduced 16x10 raster for frame-level
// corners, and a CLK_DIV=1 / active-high-sync variant.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       pt0, vid0, hs0, vs0, fs0;
    logic [9:0] x0, y0;
    logic       pt1, vid1, hs1, vs1, fs1;
    logic [9:0] x1, y1;
    logic       pt2, vid2, hs2, vs2, fs2;
    logic [9:0] x2, y2;

    vga_timing_gen u0 (
        .clk(clk), .rst(rst), .pix_tick(pt0), .pixel_x(x0), .pixel_y(y0),
        .vid_on(vid0), .hsync(hs0), .vsync(vs0), .frame_start(fs0)
    );

    // 16x10 raster, 2 clks per pixel: hsync x in [10,12], vsync y in [7,8], frame = 320 clks.
    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u1 (
        .clk(clk), .rst(rst), .pix_tick(pt1), .pixel_x(x1), .pixel_y(y1),
        .vid_on(vid1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
    );

    vga_timing_gen #(.CLK_DIV(1), .SYNC_ACTIVE(1'b1)) u2 (
        .clk(clk), .rst(rst), .pix_tick(pt2), .pixel_x(x2), .pixel_y(y2),
        .vid_on(vid2), .hsync(hs2), .vsync(vs2), .frame_start(fs2)
    );

    typedef struct {
        int         edge_n;
        logic [9:0] x;
        logic [9:0] y;
        logic       vid;
        logic       hs;
        logic       vs;
    } vec_t;

    vec_t tbl[16];
    int   tests = 0;
    int   fails = 0;
    int   n     = 0;
    int   fs_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clk edge; outputs are sampled 1 time unit later. Records small-raster frame_start edges.
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        if (fs1 === 1'b1) fs_q.push_back(n);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        n   = 0;
        fs_q.delete();
    endtask

    initial begin
        int first_tick, bad_tick, xy_bad, hs_first, hs_low, y_inc, vs_low;
        int t2_low, y2_inc, hs2_first, hs2_high, vs2_high, sync_low, p;

        // Small raster samples taken on the 2nd clk of pixel p = x + 16*y, i.e. after edge 2p+2.
        tbl[0]  = '{2,   10'd0,  10'd0, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{16,  10'd7,  10'd0, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{18,  10'd8,  10'd0, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{20,  10'd9,  10'd0, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{22,  10'd10, 10'd0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{26,  10'd12, 10'd0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{28,  10'd13, 10'd0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{32,  10'd15, 10'd0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{34,  10'd0,  10'd1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{176, 10'd7,  10'd5, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{194, 10'd0,  10'd6, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{226, 10'd0,  10'd7, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{288, 10'd15, 10'd8, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{290, 10'd0,  10'd9, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{320, 10'd15, 10'd9, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{322, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1};

        // Reset state
        #2 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_u0", {pt0, x0, y0, vid0, hs0, vs0, fs0}, {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        check("rst_u1", {pt1, x1, y1, vid1, hs1, vs1, fs1}, {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        check("rst_u2_sync", {pt2, hs2, vs2}, 3'b000);

        // Default line timing and the CLK_DIV=1 / active-high variant
        release_rst();
        first_tick = -1; bad_tick = 0; xy_bad = 0; hs_first = -1; hs_low = 0; y_inc = -1; vs_low = 0;
        t2_low = 0; y2_inc = -1; hs2_first = -1; hs2_high = 0; vs2_high = 0;
        for (int k = 1; k <= 3300; k++) begin
            tick();
            if (pt0 === 1'b1 && first_tick < 0) first_tick = n;
            if (pt0 !== ((n >= 4) && (n % 4 == 0))) bad_tick++;
            p = (n - 1) / 4;
            if (x0 !== 10'(p % 800) || y0 !== 10'(p / 800) || vid0 !== ((p % 800) < 640)) xy_bad++;
            if (hs0 === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = n;
            end
            if (y0 !== 10'd0 && y_inc < 0) y_inc = n;
            if (vs0 !== 1'b1) vs_low++;
            if (n == 2557) check("vid_639_0", {x0, vid0}, {10'd639, 1'b1});
            if (n == 2561) check("vid_640_0", {x0, vid0}, {10'd640, 1'b0});
            if (pt2 !== 1'b1) t2_low++;
            if (y2 !== 10'd0 && y2_inc < 0) y2_inc = n;
            if (n <= 900 && hs2 === 1'b1) begin
                hs2_high++;
                if (hs2_first < 0) hs2_first = n;
            end
            if (vs2 !== 1'b0) vs2_high++;
        end
        check("first_tick_edge", first_tick, 4);
        check("tick_spacing_errs", bad_tick, 0);
        check("xy_track_errs", xy_bad, 0);
        check("hsync_first_low_edge", hs_first, 2626);
        check("hsync_low_clks", hs_low, 384);
        check("y_inc_edge", y_inc, 3201);
        check("vsync_idle_errs", vs_low, 0);
        check("u2_tick_low_clks", t2_low, 0);
        check("u2_line_len_edge", y2_inc, 801);
        check("u2_hsync_first_high", hs2_first, 658);
        check("u2_hsync_high_clks", hs2_high, 96);
        check("u2_vsync_idle_errs", vs2_high, 0);

        // Small raster: table vectors plus frame_start spacing
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        release_rst();
        for (int i = 0; i < 16; i++) begin
            while (n < tbl[i].edge_n) tick();
            check($sformatf("vec%0d_xy_vid_hs_vs", i), {x1, y1, vid1, hs1, vs1},
                  {tbl[i].x, tbl[i].y, tbl[i].vid, tbl[i].hs, tbl[i].vs});
        end
        while (n < 700) tick();
        check("fs_count", fs_q.size(), 2);
        check("fs_first_edge", (fs_q.size() > 0) ? fs_q[0] : -1, 321);
        check("fs_second_edge", (fs_q.size() > 1) ? fs_q[1] : -1, 641);

        // Async reset mid-frame at (11,7), inside both sync windows
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        release_rst();
        while (n < 248) tick();
        check("mid_pre", {x1, y1, hs1, vs1}, {10'd11, 10'd7, 1'b0, 1'b0});
        #1 rst = 1'b1;
        #1;
        check("mid_async_clear", {pt1, x1, y1, vid1, hs1, vs1, fs1},
              {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        release_rst();
        sync_low = 0;
        for (int k = 1; k <= 330; k++) begin
            tick();
            if (n <= 21 && (hs1 !== 1'b1 || vs1 !== 1'b1)) sync_low++;
        end
        check("mid_no_stale_sync", sync_low, 0);
        check("mid_fs_first_edge", (fs_q.size() > 0) ? fs_q[0] : -1, 321);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
